// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file read-port constants and types
package rf_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 64;
    localparam int RF_NREGS  = 32;

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;
    typedef logic [RF_DATA_W-1:0] rf_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, one-hot grant
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic          found;
    logic [IW-1:0] idx;

    // Scan from the pointer upward, wrapping at NREQ; first requester wins.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int off = 0; off < NREQ; off++) begin
            idx = IW'((int'(ptr) + off) % NREQ);
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_read_arbiter.sv
// rtl/rf_read_arbiter.sv - round-robin sharing of the register-file read port
module rf_read_arbiter
    import rf_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DATA_W = RF_DATA_W,
    parameter int ID_W   = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    output logic [NREQ-1:0]        gnt,
    input  logic                   stall,
    output logic [ADDR_W-1:0]      rf_sel,
    input  logic [DATA_W-1:0]      rf_data,
    output logic                   rd_valid,
    output logic [ID_W-1:0]        rd_id,
    output logic [DATA_W-1:0]      rd_data
);

    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   gnt_id;
    logic [ID_W-1:0]   ptr_next;
    logic [ADDR_W-1:0] gnt_addr;
    logic              any_gnt;
    logic              s1_valid;
    logic [ID_W-1:0]   s1_id;

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .req (req),
        .ptr (ptr),
        .en  (reset_n && !stall),
        .gnt (gnt)
    );

    always_comb begin
        any_gnt  = 1'b0;
        gnt_id   = '0;
        gnt_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                any_gnt  = 1'b1;
                gnt_id   = ID_W'(i);
                gnt_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
        ptr_next = (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + ID_W'(1);
    end

    // Stage 1 drives the mux select; stage 2 captures the settled mux output.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr      <= '0;
            rf_sel   <= '0;
            s1_valid <= 1'b0;
            s1_id    <= '0;
            rd_valid <= 1'b0;
            rd_id    <= '0;
            rd_data  <= '0;
        end else if (!stall) begin
            if (any_gnt) begin
                ptr    <= ptr_next;
                rf_sel <= gnt_addr;
                s1_id  <= gnt_id;
            end
            s1_valid <= any_gnt;
            rd_valid <= s1_valid;
            if (s1_valid) begin
                rd_id   <= s1_id;
                rd_data <= rf_data;
            end
        end
    end

endmodule

// File: tb/tb_rf_read_arbiter.sv
// tb/tb_rf_read_arbiter.sv - directed self-checking bench for rf_read_arbiter
module tb_rf_read_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req;
    logic [19:0] req_addr;
    logic [3:0]  gnt;
    logic        stall;
    logic [4:0]  rf_sel;
    logic [63:0] rf_data;
    logic        rd_valid;
    logic [1:0]  rd_id;
    logic [63:0] rd_data;

    int checks = 0;
    int errors = 0;

    rf_read_arbiter dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .req_addr (req_addr),
        .gnt      (gnt),
        .stall    (stall),
        .rf_sel   (rf_sel),
        .rf_data  (rf_data),
        .rd_valid (rd_valid),
        .rd_id    (rd_id),
        .rd_data  (rd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] xval(input logic [4:0] a);
        return 64'h0123_4567_0000_0000 + 64'({a, a, a});
    endfunction

    assign rf_data = xval(rf_sel);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [4:0] a);
        req_addr[i*5 +: 5] = a;
    endtask

    logic [3:0] rr_gnt  [6];
    int         rr_id   [6];
    logic [4:0] rr_addr [4];
    logic [3:0] ws_gnt  [3];

    initial begin
        rr_gnt  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        rr_id   = '{0, 1, 2, 3, 0, 1};
        rr_addr = '{5'd31, 5'd3, 5'd12, 5'd7};
        ws_gnt  = '{4'b0001, 4'b0100, 4'b0001};

        reset_n  = 1'b0;
        stall    = 1'b0;
        req      = 4'b1111;
        req_addr = '0;
        for (int i = 0; i < 4; i++) set_addr(i, rr_addr[i]);

        // Reset held two cycles with every requester asserting
        for (int c = 0; c < 2; c++) begin
            step();
            check("rst_gnt", 64'(gnt), 64'd0);
            check("rst_valid", 64'(rd_valid), 64'd0);
            check("rst_sel", 64'(rf_sel), 64'd0);
        end

        // Round robin with all four requesting
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            check("rr_gnt", 64'(gnt), 64'(rr_gnt[c]));
            if (c >= 1) check("rr_sel", 64'(rf_sel), 64'(rr_addr[rr_id[c-1]]));
            check("rr_valid", 64'(rd_valid), (c >= 2) ? 64'd1 : 64'd0);
            if (c >= 2) begin
                check("rr_id", 64'(rd_id), 64'(rr_id[c-2]));
                check("rr_data", rd_data, xval(rr_addr[rr_id[c-2]]));
            end
            step();
        end

        // Move pointer to 3, then wrap and skip with req=0101
        req = 4'b0100;
        #1;
        check("ws_pre", 64'(gnt), 64'b0100);
        step();
        req = 4'b0101;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("ws_gnt", 64'(gnt), 64'(ws_gnt[c]));
            step();
        end
        req = 4'b0000;
        step();
        step();
        step();

        // Stall after a grant to requester 1 at address 9
        req = 4'b0010;
        set_addr(1, 5'd9);
        #1;
        check("st_gnt", 64'(gnt), 64'b0010);
        step();
        req   = 4'b0001;
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("st_gnt_hold", 64'(gnt), 64'd0);
            check("st_sel", 64'(rf_sel), 64'd9);
            check("st_valid", 64'(rd_valid), 64'd0);
            step();
        end
        stall = 1'b0;
        req   = 4'b0000;
        #1;
        check("st_rel_valid", 64'(rd_valid), 64'd0);
        step();
        check("st_valid_up", 64'(rd_valid), 64'd1);
        check("st_id", 64'(rd_id), 64'd1);
        check("st_data", rd_data, xval(5'd9));
        step();
        check("st_valid_once", 64'(rd_valid), 64'd0);

        // Reset mid-flight after a grant to requester 2
        req = 4'b0100;
        set_addr(2, 5'd20);
        #1;
        check("rf_gnt", 64'(gnt), 64'b0100);
        step();
        req     = 4'b0000;
        reset_n = 1'b0;
        #1;
        check("rf_gnt_rst", 64'(gnt), 64'd0);
        step();
        check("rf_valid0", 64'(rd_valid), 64'd0);
        check("rf_sel0", 64'(rf_sel), 64'd0);
        step();
        check("rf_valid1", 64'(rd_valid), 64'd0);
        reset_n = 1'b1;
        req     = 4'b1111;
        #1;
        check("rf_ptr0", 64'(gnt), 64'b0001);
        step();
        req = 4'b0000;
        check("rf_valid2", 64'(rd_valid), 64'd0);
        step();
        step();
        step();

        // Single requester back-to-back
        for (int c = 0; c < 7; c++) begin
            if (c < 4) begin
                req = 4'b1000;
                set_addr(3, 5'(c + 1));
            end else begin
                req = 4'b0000;
            end
            #1;
            if (c < 4) check("b2b_gnt", 64'(gnt), 64'b1000);
            check("b2b_valid", 64'(rd_valid), (c >= 2 && c < 6) ? 64'd1 : 64'd0);
            if (c >= 2 && c < 6) begin
                check("b2b_id", 64'(rd_id), 64'd3);
                check("b2b_data", rd_data, xval(5'(c - 1)));
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
